// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: per-key 2-flop synchroniser plus a debounce FSM
// producing a debounced level and one-cycle press / release / long-press pulses.
module key_filter_multi #(
  parameter int unsigned             KEY_NUM    = 4,
  parameter bit                      ACTIVE_LOW = 1'b1,
  parameter int unsigned             CNT_W      = 20,
  parameter logic [CNT_W-1:0]        DEB_MAX    = 20'd999_999,
  parameter int unsigned             LONG_W     = 26,
  parameter logic [LONG_W-1:0]       LONG_MAX   = 26'd49_999_999
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    PRESSED,
    RELEASE_DEB
  } state_t;

  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] pressed;

  // Synchronisers reset to the released pin level so no phantom press follows reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= ACTIVE_LOW ? '1 : '0;
      sync2_q <= ACTIVE_LOW ? '1 : '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ {KEY_NUM{ACTIVE_LOW}};

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_chan
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    deb_q, deb_d;
    logic [LONG_W-1:0]   long_cnt_q, long_cnt_d;
    logic                long_done_q, long_done_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;

    always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      long_cnt_d  = long_cnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed[g]) begin
            state_d = PRESS_DEB;
            deb_d   = '0;
          end
        end
        PRESS_DEB: begin
          if (!pressed[g]) begin
            state_d = IDLE;
            deb_d   = '0;
          end else if (deb_q == DEB_MAX) begin
            state_d     = PRESSED;
            press_d     = 1'b1;
            level_d     = 1'b1;
            deb_d       = '0;
            long_cnt_d  = '0;
            long_done_d = 1'b0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        PRESSED: begin
          // Long-press count saturates at LONG_MAX; long_done blocks a second pulse.
          if (!long_done_q) begin
            if (long_cnt_q == LONG_MAX) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
            end else begin
              long_cnt_d = long_cnt_q + 1'b1;
            end
          end
          if (!pressed[g]) begin
            state_d = RELEASE_DEB;
            deb_d   = '0;
          end
        end
        RELEASE_DEB: begin
          if (pressed[g]) begin
            state_d = PRESSED;
            deb_d   = '0;
          end else if (deb_q == DEB_MAX) begin
            state_d   = IDLE;
            release_d = 1'b1;
            level_d   = 1'b0;
            deb_d     = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          deb_d   = '0;
        end
      endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q     <= IDLE;
        deb_q       <= '0;
        long_cnt_q  <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        deb_q       <= deb_d;
        long_cnt_q  <= long_cnt_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
      end
    end

    assign key_state[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi with DEB_MAX=9, LONG_MAX=99:
// a per-cycle vector table plus hand sequences for bounce, long press and reset.
module tb_key_filter_multi;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state, key_press, key_release, key_long;

  key_filter_multi #(
    .KEY_NUM   (4),
    .ACTIVE_LOW(1'b1),
    .CNT_W     (20),
    .DEB_MAX   (20'd9),
    .LONG_W    (26),
    .LONG_MAX  (26'd99)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Pulse monitor: edge index (1 = first edge after clear_mon) and count per channel.
  int ec;
  int press_cnt[4], press_at[4];
  int rel_cnt[4],   rel_at[4];
  int long_cnt[4],  long_at[4];
  int overlap = 0;

  typedef struct {
    logic [3:0] key;
    int         n;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    ec = 0;
    for (int c = 0; c < 4; c++) begin
      press_cnt[c] = 0; press_at[c] = -1;
      rel_cnt[c]   = 0; rel_at[c]   = -1;
      long_cnt[c]  = 0; long_at[c]  = -1;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      ec++;
      for (int c = 0; c < 4; c++) begin
        if (key_press[c])   begin press_cnt[c]++; press_at[c] = ec; end
        if (key_release[c]) begin rel_cnt[c]++;   rel_at[c]   = ec; end
        if (key_long[c])    begin long_cnt[c]++;  long_at[c]  = ec; end
        if ((32'(key_press[c]) + 32'(key_release[c]) + 32'(key_long[c])) > 1) overlap++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] prev_st;

    //            key   n  state  press  rel   long
    tbl[0]  = '{4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'hE, 12, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[3]  = '{4'hE, 21, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'hF, 12, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[6]  = '{4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'h6, 12, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{4'h6,  1, 4'h9, 4'h9, 4'h0, 4'h0};
    tbl[9]  = '{4'h6, 37, 4'h9, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{4'hF, 12, 4'h9, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{4'hF,  1, 4'h0, 4'h0, 4'h9, 4'h0};
    tbl[12] = '{4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0};

    sys_rst_n = 1'b0;
    key_in    = 4'hF;
    #1;
    check("reset_outputs", {16'h0, key_state, key_press, key_release, key_long}, 32'h0);
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    clear_mon();

    // Clean press on key 0, then simultaneous short press on keys 0 and 3.
    prev_st = 4'h0;
    for (int i = 0; i < 13; i++) begin
      key_in = tbl[i].key;
      for (int k = 0; k < tbl[i].n - 1; k++) begin
        step(1);
        check($sformatf("tbl%0d_mid", i),
              {16'h0, key_state, key_press, key_release, key_long},
              {16'h0, prev_st, 12'h000});
      end
      step(1);
      check($sformatf("tbl%0d_state", i),   {28'h0, key_state},   {28'h0, tbl[i].st});
      check($sformatf("tbl%0d_press", i),   {28'h0, key_press},   {28'h0, tbl[i].pr});
      check($sformatf("tbl%0d_release", i), {28'h0, key_release}, {28'h0, tbl[i].rl});
      check($sformatf("tbl%0d_long", i),    {28'h0, key_long},    {28'h0, tbl[i].lg});
      prev_st = tbl[i].st;
    end

    // Bounce on key 1: low 8, high 2, then low; press 13 edges after final falling sample (edge 11).
    clear_mon();
    key_in = 4'hD; step(8);
    check("bounce_no_press_yet", 32'(press_cnt[1]), 32'd0);
    key_in = 4'hF; step(2);
    key_in = 4'hD; step(15);
    check("bounce_press_cnt",  32'(press_cnt[1]), 32'd1);
    check("bounce_press_edge", 32'(press_at[1]),  32'd23);
    check("bounce_state",      {28'h0, key_state}, 32'h2);
    clear_mon();
    key_in = 4'hF; step(15);
    check("bounce_rel_edge", 32'(rel_at[1]),  32'd13);
    check("bounce_rel_cnt",  32'(rel_cnt[1]), 32'd1);

    // Long press on key 2: press at edge 13, key_long once at edge 113.
    clear_mon();
    key_in = 4'hB; step(200);
    check("long_press_edge", 32'(press_at[2]), 32'd13);
    check("long_edge",       32'(long_at[2]),  32'd113);
    check("long_cnt",        32'(long_cnt[2]), 32'd1);
    check("long_state",      {28'h0, key_state}, 32'h4);
    check("long_others",     32'(press_cnt[0] + press_cnt[1] + press_cnt[3]), 32'd0);
    clear_mon();
    key_in = 4'hF; step(15);
    check("long_rel_edge",   32'(rel_at[2]),   32'd13);
    check("long_rel_state",  {28'h0, key_state}, 32'h0);
    check("long_no_refire",  32'(long_cnt[2]), 32'd0);

    // Reset with key 0 mid-debounce (deb_cnt=5 after edge 8), then fresh debounce.
    clear_mon();
    key_in = 4'hE; step(8);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {16'h0, key_state, key_press, key_release, key_long}, 32'h0);
    step(2);
    sys_rst_n = 1'b1;
    clear_mon();
    step(16);
    check("rst_press_edge", 32'(press_at[0]), 32'd13);
    check("rst_press_cnt",  32'(press_cnt[0]), 32'd1);
    check("rst_state_set",  {28'h0, key_state}, 32'h1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_clear", {16'h0, key_state, key_press, key_release, key_long}, 32'h0);
    key_in = 4'hF;
    step(2);
    sys_rst_n = 1'b1;
    step(5);

    check("no_pulse_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
